// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - register file, write-back bypass and ID/EX pipeline register feeding the ALU
//
// Purpose:
//   This stage supplies operands to the 32-bit ALU. It holds the general-purpose
//   register file. Register 0 always reads as zero. The stage forwards a
//   same-cycle write-back to both read ports. It selects operand B from either
//   register rt or the sign-extended immediate. A, B and the ALU opcode are
//   registered together with the destination and control bits.
//
// Ports:
//   Clk, Reset_n        clock (rising edge) and asynchronous active-low reset
//   ReadReg1/ReadReg2   source register addresses for A (rs) and B (rt)
//   Imm, ALUSrc         immediate and B-operand select (1: Imm, 0: register)
//   ALUControlIn        4-bit ALU opcode of the decoded instruction
//   DestRegIn           write-back destination of the decoded instruction
//   RegWriteIn          decoded instruction writes a register
//   ValidIn             decode slot holds a real instruction
//   Stall, Flush        hold the pipeline register / replace it with a bubble
//   WriteEnable         write-back strobe
//   WriteReg, WriteData write-back address and data
//   A, B, ALUControl    registered ALU operands and opcode
//   DestReg             registered write-back destination
//   RegWriteOut         registered register-write flag
//   ValidOut            registered valid flag

module id_ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [DATA_WIDTH-1:0] Imm,
    input  logic                  ALUSrc,
    input  logic [3:0]            ALUControlIn,
    input  logic [ADDR_WIDTH-1:0] DestRegIn,
    input  logic                  RegWriteIn,
    input  logic                  ValidIn,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [3:0]            ALUControl,
    output logic [ADDR_WIDTH-1:0] DestReg,
    output logic                  RegWriteOut,
    output logic                  ValidOut
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // A write to r0 is a legal instruction whose result is discarded.
    logic wb_active;
    assign wb_active = WriteEnable && (WriteReg != '0);

    // Write-back is independent of Stall and Flush. The instruction in
    // write-back is older than anything being held or squashed here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with same-cycle write-back bypass
    // ------------------------------------------------------------------
    // Without the bypass, a read would see the old value, because the write
    // lands on the same edge that captures the operands. The r0 check is made
    // before the array read, so r0 reads as zero even if that entry never
    // got written.
    logic                  hit1;
    logic                  hit2;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] b_next;

    assign hit1 = wb_active && (WriteReg == ReadReg1);
    assign hit2 = wb_active && (WriteReg == ReadReg2);

    always_comb begin
        src1 = '0;
        if (hit1) begin
            src1 = WriteData;
        end else if (ReadReg1 != '0) begin
            src1 = regs[ReadReg1];
        end
    end

    always_comb begin
        src2 = '0;
        if (hit2) begin
            src2 = WriteData;
        end else if (ReadReg2 != '0) begin
            src2 = regs[ReadReg2];
        end
    end

    // Imm arrives already sign-extended to full width.
    assign b_next = ALUSrc ? Imm : src2;

    // ------------------------------------------------------------------
    // ID/EX pipeline register: Flush > Stall > load
    // ------------------------------------------------------------------
    // A load with ValidIn=0 produces the same all-zero bubble as Flush.
    // Downstream logic therefore sees only one kind of bubble.
    logic make_bubble;
    assign make_bubble = Flush || (!Stall && !ValidIn);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            A           <= '0;
            B           <= '0;
            ALUControl  <= 4'b0000;
            DestReg     <= '0;
            RegWriteOut <= 1'b0;
            ValidOut    <= 1'b0;
        end else if (make_bubble) begin
            A           <= '0;
            B           <= '0;
            ALUControl  <= 4'b0000;
            DestReg     <= '0;
            RegWriteOut <= 1'b0;
            ValidOut    <= 1'b0;
        end else if (!Stall) begin
            A           <= src1;
            B           <= b_next;
            ALUControl  <= ALUControlIn;
            DestReg     <= DestRegIn;
            RegWriteOut <= RegWriteIn;
            ValidOut    <= 1'b1;
        end
        // Stall: everything holds. Held operands are deliberately not
        // refreshed by write-backs. Upstream re-issues the instruction
        // when the hazard clears.
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage

module tb_id_ex_operand_stage;

    typedef struct packed {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] imm;
        logic        alusrc;
        logic [3:0]  alu;
        logic [4:0]  dest;
        logic        rw;
        logic        valid;
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
    } stim_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu;
        logic [4:0]  dest;
        logic        rw;
        logic        valid;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  ReadReg1, ReadReg2, DestRegIn, WriteReg;
    logic [31:0] Imm, WriteData;
    logic        ALUSrc, RegWriteIn, ValidIn, Stall, Flush, WriteEnable;
    logic [3:0]  ALUControlIn;
    logic [31:0] A, B;
    logic [3:0]  ALUControl;
    logic [4:0]  DestReg;
    logic        RegWriteOut, ValidOut;

    int n_cmp = 0;
    int n_bad = 0;

    out_t        exp_q[$];
    logic [31:0] mregs [32];
    out_t        mout;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .Clk(clk), .Reset_n(rst_n),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .Imm(Imm), .ALUSrc(ALUSrc),
        .ALUControlIn(ALUControlIn), .DestRegIn(DestRegIn), .RegWriteIn(RegWriteIn),
        .ValidIn(ValidIn), .Stall(Stall), .Flush(Flush),
        .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
        .A(A), .B(B), .ALUControl(ALUControl), .DestReg(DestReg),
        .RegWriteOut(RegWriteOut), .ValidOut(ValidOut)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.a = A; o.b = B; o.alu = ALUControl; o.dest = DestReg;
        o.rw = RegWriteOut; o.valid = ValidOut;
        return o;
    endfunction

    // Monitor: each negedge, compare the outputs against the oldest pending expectation.
    initial begin
        out_t e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_out();
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got A=%h B=%h alu=%h dst=%0d rw=%b v=%b, expected A=%h B=%h alu=%h dst=%0d rw=%b v=%b",
                             $time, g.a, g.b, g.alu, g.dest, g.rw, g.valid,
                             e.a, e.b, e.alu, e.dest, e.rw, e.valid);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t wrs(input logic [4:0] r, input logic [31:0] d);
        stim_t s = '0;
        s.we = 1'b1; s.wr = r; s.wd = d;
        return s;
    endfunction

    function automatic stim_t ld(input logic [4:0] r1, input logic [4:0] r2, input logic asrc,
                                 input logic [31:0] imm, input logic [3:0] alu);
        stim_t s = '0;
        s.rr1 = r1; s.rr2 = r2; s.alusrc = asrc; s.imm = imm; s.alu = alu;
        s.dest = 5'd17; s.rw = 1'b1; s.valid = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ReadReg1 = s.rr1; ReadReg2 = s.rr2; Imm = s.imm; ALUSrc = s.alusrc;
        ALUControlIn = s.alu; DestRegIn = s.dest; RegWriteIn = s.rw; ValidIn = s.valid;
        Stall = s.stall; Flush = s.flush;
        WriteEnable = s.we; WriteReg = s.wr; WriteData = s.wd;
    endtask

    // Reference read: r0 is zero, a same-cycle write-back wins, otherwise the stored value.
    function automatic logic [31:0] msrc(input stim_t s, input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (s.we && s.wr == r) return s.wd;
        return mregs[r];
    endfunction

    // Called at a negedge. Drives one decode slot, pushes the expected result
    // at the capturing edge and returns at the following negedge.
    task automatic cycle(input stim_t s);
        out_t e;
        drive(s);
        if (s.flush || (!s.stall && !s.valid)) begin
            e = '0;
        end else if (s.stall) begin
            e = mout;
        end else begin
            e.a = msrc(s, s.rr1);
            e.b = s.alusrc ? s.imm : msrc(s, s.rr2);
            e.alu = s.alu; e.dest = s.dest; e.rw = s.rw; e.valid = 1'b1;
        end
        @(posedge clk);
        mout = e;
        exp_q.push_back(e);
        if (s.we && s.wr != 5'd0) mregs[s.wr] = s.wd;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mout = '0;
    endtask

    // Called at a negedge. Asserts reset between edges and checks that it acts
    // without a clock edge. Reset is released at the next negedge.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        drive(ld(5'd5, 5'd5, 1'b0, 32'd0, 4'b0010));
        #1;
        check({tag, " A immediate"}, A, 32'd0);
        check({tag, " B immediate"}, B, 32'd0);
        check({tag, " ValidOut immediate"}, {31'd0, ValidOut}, 32'd0);
        @(negedge clk);
        check({tag, " ValidOut held in reset"}, {31'd0, ValidOut}, 32'd0);
        check({tag, " ALUControl held in reset"}, {28'd0, ALUControl}, 32'd0);
        model_reset();
        drive(idle());
        rst_n = 1'b1;
    endtask

    logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    initial begin
        stim_t s;
        model_reset();
        drive(idle());
        #2;
        async_reset("initial reset");

        // Basic load
        cycle(wrs(5'd5, 32'd5));
        cycle(wrs(5'd10, 32'd10));
        cycle(ld(5'd5, 5'd10, 1'b0, 32'd0, 4'b0010));
        check("basic A", A, 32'd5);
        check("basic B", B, 32'd10);
        check("basic ALUControl", {28'd0, ALUControl}, 32'h2);
        check("basic ValidOut", {31'd0, ValidOut}, 32'd1);

        // Same-cycle bypass on both ports
        s = ld(5'd3, 5'd3, 1'b0, 32'd0, 4'b0001);
        s.we = 1'b1; s.wr = 5'd3; s.wd = 32'hFFFF0000;
        cycle(s);
        check("bypass A", A, 32'hFFFF0000);
        check("bypass B", B, 32'hFFFF0000);

        // r0 write discarded, immediate select
        cycle(wrs(5'd0, 32'hDEADBEEF));
        cycle(ld(5'd0, 5'd0, 1'b1, 32'hFFFFFFF9, 4'b0110));
        check("r0 A", A, 32'd0);
        check("imm B", B, 32'hFFFFFFF9);
        // Bypass must not apply to r0 either
        s = ld(5'd0, 5'd0, 1'b0, 32'd0, 4'b0000);
        s.we = 1'b1; s.wr = 5'd0; s.wd = 32'h12345678;
        cycle(s);
        check("r0 bypass A", A, 32'd0);
        check("r0 bypass B", B, 32'd0);

        // Stall holds outputs while the register file still takes writes
        cycle(wrs(5'd1, 32'd3));
        cycle(wrs(5'd2, 32'd7));
        cycle(ld(5'd1, 5'd2, 1'b0, 32'd0, 4'b0111));
        for (int i = 0; i < 3; i++) begin
            s = ld(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, $urandom, 4'b1100);
            s.stall = 1'b1;
            if (i == 0) begin s.we = 1'b1; s.wr = 5'd3; s.wd = 32'd9; end
            cycle(s);
            check("stall A", A, 32'd3);
            check("stall B", B, 32'd7);
            check("stall ALUControl", {28'd0, ALUControl}, 32'h7);
        end
        cycle(ld(5'd3, 5'd0, 1'b0, 32'd0, 4'b0010));
        check("post-stall r3", A, 32'd9);

        // Flush beats stall
        s = ld(5'd1, 5'd2, 1'b0, 32'd0, 4'b0010);
        s.stall = 1'b1; s.flush = 1'b1;
        cycle(s);
        check("flush ValidOut", {31'd0, ValidOut}, 32'd0);
        check("flush RegWriteOut", {31'd0, RegWriteOut}, 32'd0);
        check("flush ALUControl", {28'd0, ALUControl}, 32'd0);

        // ValidIn=0 load is a bubble
        cycle(ld(5'd1, 5'd2, 1'b0, 32'd0, 4'b0110));
        s = ld(5'd1, 5'd2, 1'b0, 32'd0, 4'b0110);
        s.valid = 1'b0;
        cycle(s);
        check("bubble ValidOut", {31'd0, ValidOut}, 32'd0);
        check("bubble RegWriteOut", {31'd0, RegWriteOut}, 32'd0);
        check("bubble A", A, 32'd0);

        // Randomized traffic; narrow address range half the time to provoke bypass hits
        for (int i = 0; i < 400; i++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            s.rr1    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s.rr2    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s.wr     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            s.imm    = $urandom;
            s.wd     = $urandom;
            s.alusrc = ($urandom_range(0, 3) == 0);
            s.alu    = ops[$urandom_range(0, 5)];
            s.dest   = 5'($urandom_range(0, 31));
            s.rw     = 1'($urandom_range(0, 1));
            s.valid  = ($urandom_range(0, 9) < 8);
            s.stall  = ($urandom_range(0, 9) < 2);
            s.flush  = ($urandom_range(0, 9) == 0);
            s.we     = ($urandom_range(0, 9) < 6);
            cycle(s);
        end

        // Mid-run reset clears the register file
        cycle(wrs(5'd5, 32'd5));
        async_reset("mid reset");
        cycle(ld(5'd5, 5'd5, 1'b0, 32'd0, 4'b0010));
        check("after reset r5", A, 32'd0);
        check("after reset valid", {31'd0, ValidOut}, 32'd1);

        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Operand-supply stage directly upstream of the 32-bit ALU.
- Holds the 32x32 general-purpose register file with write-back bypass, selects the B operand (register or immediate), and registers A, B and the 4-bit ALU control code into the ID/EX pipeline register.
- Its outputs drive the ALU's A, B and ALUControl inputs one cycle after decode.
- Supports pipeline stall and flush.

Parameters:
- DATA_WIDTH, 32, operand and register width.
- REG_COUNT, 32, number of architectural registers; register 0 hardwired to zero.
- ADDR_WIDTH, 5, register address width (log2 REG_COUNT).

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ReadReg1  in  5  source register for A (rs).
- ReadReg2  in  5  source register for B (rt).
- Imm  in  32  sign-extended immediate.
- ALUSrc  in  1  1: B takes Imm; 0: B takes register ReadReg2.
- ALUControlIn  in  4  ALU opcode (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
- DestRegIn  in  5  write-back destination of this instruction.
- RegWriteIn  in  1  instruction writes a register.
- ValidIn  in  1  decode slot holds a real instruction.
- Stall  in  1  hold the pipeline register.
- Flush  in  1  replace the pipeline register contents with a bubble.
- WriteEnable  in  1  write-back strobe.
- WriteReg  in  5  write-back address.
- WriteData  in  32  write-back data.
- A  out  32  registered ALU operand A.
- B  out  32  registered ALU operand B.
- ALUControl  out  4  registered ALU opcode.
- DestReg  out  5  registered destination.
- RegWriteOut  out  1  registered write enable.
- ValidOut  out  1  registered valid.

Behaviour:
- Reset:
  - Reset_n low asynchronously clears all 32 registers, A, B, ALUControl (0000), DestReg, RegWriteOut and ValidOut to 0 without waiting for a clock edge.
  - Outputs stay 0 while Reset_n is low.
  - First capture occurs on the first rising edge after release.
- Register file:
  - Write on rising edge when WriteEnable=1 and WriteReg!=0.
  - Writes to r0 are discarded; r0 always reads 0.
  - Writes occur regardless of Stall or Flush.
- Read bypass (combinational, before the pipeline register):
  - srcX = WriteData when WriteEnable=1, WriteReg==ReadRegX and WriteReg!=0.
  - Otherwise srcX = regs[ReadRegX].
  - Applies to both ports independently, including both ports reading the same register.
- Operand B select: Bnext = ALUSrc ? Imm : src2. Imm is passed unmodified; no width change.
- Pipeline register update priority on each rising edge: Flush > Stall > load.
  - Flush=1: A=0, B=0, ALUControl=0000, DestReg=0, RegWriteOut=0, ValidOut=0.
  - Stall=1 (Flush=0): all outputs hold. Held A/B are not refreshed by write-backs during the stall.
  - Load, ValidIn=1: A=src1, B=Bnext, ALUControl=ALUControlIn, DestReg=DestRegIn, RegWriteOut=RegWriteIn, ValidOut=1.
  - Load, ValidIn=0: bubble, identical to Flush.
- Latency: 1 cycle from decode inputs to outputs.
- Hazards: the write-back bypass resolves exactly the same-cycle case. Stall covers other RAW hazards, and upstream hazard detection asserts it. The block does no hazard detection itself.

Test Plan:
- Reset: write r5=5, then assert Reset_n=0 between clock edges -> A, B, ValidOut are 0 immediately. After release, a read of r5 loads A=0.
- Basic load:
  - Setup: write r5=5, r10=10.
  - Stimulus: ReadReg1=5, ReadReg2=10, ALUSrc=0, ALUControlIn=0010, ValidIn=1.
  - Response: next edge A=5, B=10, ALUControl=0010, ValidOut=1.
- Bypass: in one cycle WriteEnable=1, WriteReg=3, WriteData=FFFF0000, ReadReg1=3, ReadReg2=3, ALUSrc=0 -> A=B=FFFF0000 at the next edge.
- r0 and immediate: write DEADBEEF to r0, then ReadReg1=0, ALUSrc=1, Imm=FFFFFFF9 -> A=0, B=FFFFFFF9.
- Stall:
  - Setup: load A=3, B=7, opcode 0111.
  - Stimulus: hold Stall=1 for 3 edges while inputs change and r3 is written to 9.
  - Response: outputs remain 3/7/0111. After Stall drops, a read of r3 gives 9.
- Flush and bubble:
  - Flush=1 together with Stall=1 -> ValidOut=0, RegWriteOut=0, ALUControl=0000.
  - ValidIn=0 load -> same bubble outputs.
